spectrum_peak_buffer: RTL and testbench

- Sits directly downstream of the FFT power stage. Consumes the 64-bit |X|² stream (valid/last framed, one bin per beat, bin 0 first).
- Captures the positive-frequency half of each frame into a ping-pong buffer, scaled and saturated, for the display/readout logic.
- Reports the peak bin and peak power per frame.
- Malformed frames are flagged and never published.

---
 rtl/spectrum_peak_buffer_if.sv | 28 ++
 rtl/spectrum_peak_buffer.sv | 162 ++++++++++++++++
 tb/tb_spectrum_peak_buffer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_peak_buffer_if.sv
// Stream-in and readout bus of the spectrum peak buffer.
// The master drives the |X|^2 beats and the read address; the slave returns stored bins.
interface spectrum_peak_buffer_if #(
    parameter int AW      = 9,
    parameter int STORE_W = 32
);
    logic [63:0]        i_power;
    logic               i_valid;
    logic               i_last;
    logic [AW-1:0]      i_rd_addr;
    logic [STORE_W-1:0] o_rd_data;

    modport master (
        output i_power,
        output i_valid,
        output i_last,
        output i_rd_addr,
        input  o_rd_data
    );

    modport slave (
        input  i_power,
        input  i_valid,
        input  i_last,
        input  i_rd_addr,
        output o_rd_data
    );
endinterface

// File: rtl/spectrum_peak_buffer.sv
// Captures the positive-frequency half of each FFT power frame into a ping-pong buffer
// and reports the per-frame peak; malformed frames are rejected and never published.
module spectrum_peak_buffer #(
    parameter int FFT_N       = 1024,
    parameter int SKIP_BINS   = 1,
    parameter int STORE_W     = 32,
    parameter int STORE_SHIFT = 16,
    localparam int AW         = $clog2(FFT_N / 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spectrum_peak_buffer_if.slave bus,
    output logic                 o_frame_done,
    output logic                 o_frame_err,
    output logic [AW-1:0]        o_peak_bin,
    output logic [63:0]          o_peak_power,
    output logic [15:0]          o_frame_cnt,
    output logic                 o_busy
);

    localparam int              BW        = AW + 1;
    localparam logic [BW-1:0]   LAST_BIN  = BW'(FFT_N - 1);
    localparam logic [BW-1:0]   SKIP      = BW'(SKIP_BINS);
    localparam logic [63:0]     STORE_MAX = (64'd1 << STORE_W) - 64'd1;

    typedef enum logic {
        COLLECT,
        DROP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BW-1:0]      bcnt;
    logic               wr_bank;
    logic               pub_valid;
    logic [63:0]        run_max;
    logic [AW-1:0]      run_bin;
    logic [STORE_W-1:0] rd_data;
    logic [STORE_W-1:0] mem [FFT_N];

    logic               good_end;
    logic               short_end;
    logic               long_err;
    logic               drop_end;
    logic               frame_end;
    logic               collect_beat;
    logic               store_en;
    logic               search_en;
    logic [63:0]        shifted;
    logic [STORE_W-1:0] stored;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_end  = 1'b0;
        short_end = 1'b0;
        long_err  = 1'b0;
        drop_end  = 1'b0;
        case (state)
            COLLECT: begin
                if (bus.i_valid) begin
                    if (bus.i_last && (bcnt == LAST_BIN)) begin
                        good_end = 1'b1;
                    end else if (bus.i_last) begin
                        short_end = 1'b1;
                    end else if (bcnt == LAST_BIN) begin
                        long_err  = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (bus.i_valid && bus.i_last) begin
                    drop_end  = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    assign frame_end    = good_end | short_end | long_err | drop_end;
    assign collect_beat = (state == COLLECT) && bus.i_valid;
    assign store_en     = collect_beat && !bcnt[BW-1];
    assign search_en    = store_en && (bcnt >= SKIP);
    assign shifted      = bus.i_power >> STORE_SHIFT;
    assign stored       = (shifted > STORE_MAX) ? {STORE_W{1'b1}} : shifted[STORE_W-1:0];
    assign o_busy       = (bcnt != '0) || (state == DROP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
        end else if (frame_end) begin
            bcnt <= '0;
        end else if (collect_beat) begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // Running max restarts at every frame boundary so a rejected frame cannot leak into the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max <= '0;
            run_bin <= AW'(SKIP_BINS);
        end else if (frame_end) begin
            run_max <= '0;
            run_bin <= AW'(SKIP_BINS);
        end else if (search_en && (bus.i_power > run_max)) begin
            run_max <= bus.i_power;
            run_bin <= bcnt[AW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_peak_bin   <= '0;
            o_peak_power <= '0;
            o_frame_cnt  <= '0;
            wr_bank      <= 1'b0;
            pub_valid    <= 1'b0;
        end else begin
            o_frame_done <= good_end;
            o_frame_err  <= short_end | long_err;
            if (good_end) begin
                o_peak_bin   <= run_bin;
                o_peak_power <= run_max;
                o_frame_cnt  <= o_frame_cnt + 16'd1;
                wr_bank      <= ~wr_bank;
                pub_valid    <= 1'b1;
            end
        end
    end

    // Buffer RAM holds both banks; its contents survive reset and are masked by pub_valid.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[{wr_bank, bcnt[AW-1:0]}] <= stored;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (pub_valid) begin
            rd_data <= mem[{~wr_bank, bus.i_rd_addr}];
        end else begin
            rd_data <= '0;
        end
    end

    assign bus.o_rd_data = rd_data;

endmodule

// File: tb/tb_spectrum_peak_buffer.sv
// Self-checking bench: two instances (shift 0 and shift 4) fed the same random stream,
// compared against a frame-level reference model.
module tb_spectrum_peak_buffer;

    localparam int FFT_N = 16;
    localparam int HALF  = FFT_N / 2;
    localparam int SKIP  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tb_power = '0;
    logic        tb_valid = 1'b0;
    logic        tb_last = 1'b0;
    logic [2:0]  tb_addr = '0;

    logic        done0, err0, busy0, done1, err1, busy1;
    logic [2:0]  pbin0, pbin1;
    logic [63:0] ppow0, ppow1;
    logic [15:0] cnt0, cnt1;

    int          checks = 0;
    int          errors = 0;

    logic [63:0] frame_pw [32];
    logic [31:0] mpub [2][HALF];
    logic        mvalid = 1'b0;
    logic [2:0]  mpeak_bin = '0;
    logic [63:0] mpeak_pow = '0;
    logic [15:0] mcnt = '0;

    spectrum_peak_buffer_if #(.AW(3), .STORE_W(32)) bus0 ();
    spectrum_peak_buffer_if #(.AW(3), .STORE_W(32)) bus1 ();

    assign bus0.i_power   = tb_power;
    assign bus0.i_valid   = tb_valid;
    assign bus0.i_last    = tb_last;
    assign bus0.i_rd_addr = tb_addr;
    assign bus1.i_power   = tb_power;
    assign bus1.i_valid   = tb_valid;
    assign bus1.i_last    = tb_last;
    assign bus1.i_rd_addr = tb_addr;

    spectrum_peak_buffer #(.FFT_N(FFT_N), .SKIP_BINS(SKIP), .STORE_W(32), .STORE_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .o_frame_done(done0), .o_frame_err(err0), .o_peak_bin(pbin0),
        .o_peak_power(ppow0), .o_frame_cnt(cnt0), .o_busy(busy0)
    );

    spectrum_peak_buffer #(.FFT_N(FFT_N), .SKIP_BINS(SKIP), .STORE_W(32), .STORE_SHIFT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .o_frame_done(done1), .o_frame_err(err1), .o_peak_bin(pbin1),
        .o_peak_power(ppow1), .o_frame_cnt(cnt1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat_store(input logic [63:0] p, input int sh);
        logic [63:0] s;
        s = p >> sh;
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A good frame publishes its lower half and the strict-greater peak of bins SKIP..HALF-1.
    task automatic publishModel();
        logic [63:0] best;
        int          bin;
        best = '0;
        bin  = SKIP;
        for (int b = SKIP; b < HALF; b++) begin
            if (frame_pw[b] > best) begin
                best = frame_pw[b];
                bin  = b;
            end
        end
        for (int b = 0; b < HALF; b++) begin
            mpub[0][b] = sat_store(frame_pw[b], 0);
            mpub[1][b] = sat_store(frame_pw[b], 4);
        end
        mvalid    = 1'b1;
        mpeak_bin = 3'(bin);
        mpeak_pow = best;
        mcnt      = mcnt + 16'd1;
    endtask

    task automatic driveCycle(input logic v, input logic l, input logic [63:0] p, input logic [2:0] a,
                              input logic ed, input logic ee, input logic eb);
        logic [31:0] er0, er1;
        tb_valid = v;
        tb_last  = l;
        tb_power = p;
        tb_addr  = a;
        er0 = mvalid ? mpub[0][a] : 32'd0;
        er1 = mvalid ? mpub[1][a] : 32'd0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("done0", 64'(done0), 64'(ed));
        checkOutput("done1", 64'(done1), 64'(ed));
        checkOutput("err0", 64'(err0), 64'(ee));
        checkOutput("err1", 64'(err1), 64'(ee));
        checkOutput("busy0", 64'(busy0), 64'(eb));
        checkOutput("busy1", 64'(busy1), 64'(eb));
        checkOutput("rd0", 64'(bus0.o_rd_data), 64'(er0));
        checkOutput("rd1", 64'(bus1.o_rd_data), 64'(er1));
    endtask

    task automatic checkStatus();
        checkOutput("peak_bin0", 64'(pbin0), 64'(mpeak_bin));
        checkOutput("peak_bin1", 64'(pbin1), 64'(mpeak_bin));
        checkOutput("peak_pow0", ppow0, mpeak_pow);
        checkOutput("peak_pow1", ppow1, mpeak_pow);
        checkOutput("cnt0", 64'(cnt0), 64'(mcnt));
        checkOutput("cnt1", 64'(cnt1), 64'(mcnt));
    endtask

    // Sends frame_pw[0..len-1] with i_last on the final beat; len != FFT_N is malformed.
    task automatic applyStimulus(input int len, input int gap_pct);
        int  gaps;
        bit  is_last;
        for (int i = 0; i < len; i++) begin
            gaps = 0;
            while (($urandom_range(0, 99) < gap_pct) && (gaps < 4)) begin
                driveCycle(1'b0, 1'b1, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                           1'b0, 1'b0, i != 0);
                gaps++;
            end
            is_last = (i == len - 1);
            driveCycle(1'b1, is_last, frame_pw[i], 3'($urandom_range(0, 7)),
                       is_last && (len == FFT_N),
                       (is_last && (len < FFT_N)) || ((len > FFT_N) && (i == FFT_N - 1)),
                       !is_last);
        end
        tb_valid = 1'b0;
        tb_last  = 1'b0;
        if (len == FFT_N) publishModel();
    endtask

    task automatic sweep();
        for (int a = 0; a < HALF; a++) begin
            driveCycle(1'b0, 1'b0, '0, 3'(a), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic fillRandom(input int len);
        for (int i = 0; i < len; i++) begin
            frame_pw[i] = {$urandom, $urandom} >> $urandom_range(0, 44);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkStatus();
        checkOutput("rst_done0", 64'(done0), 64'd0);
        checkOutput("rst_err0", 64'(err0), 64'd0);
        checkOutput("rst_busy0", 64'(busy0), 64'd0);
        checkOutput("rst_rd0", 64'(bus0.o_rd_data), 64'd0);
        rst_n = 1'b1;
        sweep();

        $display("[TB] basic frame");
        for (int b = 0; b < FFT_N; b++) frame_pw[b] = 64'(b * 10);
        frame_pw[3] = 64'd500;
        frame_pw[0] = 64'd900;
        applyStimulus(FFT_N, 0);
        checkStatus();
        sweep();

        $display("[TB] tie frame");
        for (int b = 0; b < FFT_N; b++) frame_pw[b] = 64'd1;
        frame_pw[2] = 64'h1000;
        frame_pw[5] = 64'h1000;
        applyStimulus(FFT_N, 0);
        checkStatus();

        $display("[TB] saturation frame");
        for (int b = 0; b < FFT_N; b++) frame_pw[b] = 64'd5;
        frame_pw[1] = 64'h0000_0010_0000_0000;
        applyStimulus(FFT_N, 0);
        checkStatus();
        sweep();

        $display("[TB] short frame");
        fillRandom(10);
        applyStimulus(10, 0);
        checkStatus();
        sweep();
        fillRandom(FFT_N);
        applyStimulus(FFT_N, 0);
        checkStatus();

        $display("[TB] long frame");
        fillRandom(20);
        applyStimulus(20, 0);
        checkStatus();
        sweep();
        fillRandom(FFT_N);
        applyStimulus(FFT_N, 0);
        checkStatus();
        sweep();

        $display("[TB] random frames with gaps");
        for (int f = 0; f < 12; f++) begin
            int len;
            case ($urandom_range(0, 5))
                0:       len = $urandom_range(1, FFT_N - 1);
                1:       len = $urandom_range(FFT_N + 1, 24);
                default: len = FFT_N;
            endcase
            fillRandom(len);
            applyStimulus(len, 50);
            checkStatus();
        end
        sweep();

        $display("[TB] reset mid-frame");
        fillRandom(FFT_N);
        for (int i = 0; i < 7; i++) begin
            driveCycle(1'b1, 1'b0, frame_pw[i], 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b1);
        end
        tb_valid  = 1'b0;
        rst_n     = 1'b0;
        mvalid    = 1'b0;
        mpeak_bin = '0;
        mpeak_pow = '0;
        mcnt      = '0;
        @(posedge clk);
        @(negedge clk);
        checkStatus();
        checkOutput("mid_rst_busy1", 64'(busy1), 64'd0);
        checkOutput("mid_rst_done1", 64'(done1), 64'd0);
        checkOutput("mid_rst_err1", 64'(err1), 64'd0);
        rst_n = 1'b1;
        sweep();
        fillRandom(FFT_N);
        applyStimulus(FFT_N, 50);
        checkStatus();
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
